// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, index-width helper and buffer entry type for the instruction fetch unit
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] TEXT_BASE_DEF = 32'h0040_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched {pc, instruction} entries with flush, occupancy and full/empty flags
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner issuing program-memory reads and handing buffered instructions to decode.
// Define FETCH_PERF_CNT_EN to add saturating fetched/stall performance counters.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE = TEXT_BASE_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
    parameter int BUF_DEPTH = 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en_i,
    output logic                  mem_enable_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    input  logic [DATA_WIDTH-1:0] mem_instruction_i,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o
`endif
);
    localparam int IW = idx_width(MEMORY_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] pc, resp_pc, addr_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] occ;
    logic inflight, drop, resp, pop, room, issue, buf_full, buf_empty;
    fetch_entry_t head, entry;

    assign pop   = instr_valid_o & instr_ready_i;
    assign drop  = inflight & redirect_valid_i;
    assign resp  = inflight & ~drop;
    assign room  = buf_full ? pop : int'(occ) + int'(inflight) < BUF_DEPTH + int'(pop);
    assign issue = reset & fetch_en_i & ~redirect_valid_i & room;
    assign idx   = IW'((pc - TEXT_BASE) >> 2);
    assign entry = '{pc: resp_pc, instruction: mem_instruction_i};

    assign mem_enable_o  = issue;
    assign mem_address_o = issue ? DATA_WIDTH'(idx) : addr_q;
    // An empty buffer lets the arriving response fall through to decode in the same cycle.
    assign instr_valid_o = ~buf_empty | resp;
    assign instr_o       = ~buf_empty ? head.instruction : resp ? mem_instruction_i : '0;
    assign instr_pc_o    = ~buf_empty ? head.pc : resp ? resp_pc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            resp_pc  <= '0;
            addr_q   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid_i) begin
                pc <= redirect_pc_i & ~DATA_WIDTH'(3);
            end else if (issue) begin
                pc      <= pc + DATA_WIDTH'(PC_STEP);
                resp_pc <= pc;
                addr_q  <= DATA_WIDTH'(idx);
            end
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid_i),
        .push      (resp & ~(pop & buf_empty)),
        .pop       (pop & ~buf_empty),
        .push_data (entry),
        .head      (head),
        .count     (occ),
        .full      (buf_full),
        .empty     (buf_empty)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else if (redirect_valid_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (pop && !(&perf_fetched_o)) perf_fetched_o <= perf_fetched_o + 32'd1;
            if (instr_valid_o && !instr_ready_i && !(&perf_stall_o)) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif
endmodule
